// File: rtl/pipe_mon_pkg.sv
// pipe_mon_pkg: shared definitions for the pipeline event monitor.
//   - trace entry kinds
//   - trace entry layout {kind, reg, data, pc}, MSB first, and its width
//   - saturating increment helper (operands up to 64 bits wide)
package pipe_mon_pkg;

  localparam logic TRACE_KIND_COMMIT = 1'b0;
  localparam logic TRACE_KIND_STORE  = 1'b1;

  // Packed trace entry: {kind[1], reg[REG_W], data[DATA_W], pc[ADDR_W]}
  function automatic int trace_entry_w(input int reg_w, input int data_w, input int addr_w);
    return 1 + reg_w + data_w + addr_w;
  endfunction

  // Increments the low w bits of v, holding at all-ones instead of wrapping.
  // The caller zero-extends its counter into v and slices the low w bits back out.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] mask;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return ((v & mask) == mask) ? v : (v + 64'd1);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous show-ahead FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   push_i, din_i : write request and data (accepted when not full, or full with a pop)
//   pop_i         : read request; effective only while valid_o
//   dout_o        : head entry, zero while empty
//   valid_o       : FIFO not empty
//   full_o        : FIFO holds DEPTH entries
//   level_o       : occupancy, 0..DEPTH
module trace_fifo
  import pipe_mon_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          valid_o,
  output logic          full_o,
  output logic [AW:0]   level_o
);

  // Pointers carry one extra MSB so full and empty are distinguishable
  // when the low bits coincide.
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         empty, pop, do_push;

  assign empty   = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = pop_i & ~empty;
  // When full, the slot being written is the one being popped this edge.
  assign do_push = push_i & (~full_o | pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (pop)     rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign valid_o = ~empty;
  assign level_o = wr_q - rd_q;
  // Storage is not reset; gate the head so it reads zero while empty.
  assign dout_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/pipeline_event_monitor.sv
// pipeline_event_monitor: saturating event counters plus a commit/store trace FIFO.
//   Clk, Reset, Enable, ClearCounters : control (Reset synchronous active-high)
//   Stall, BranchTaken, Jump          : hazard/ID event taps
//   WB_* / MEM_*                      : commit and store taps
//   *Count                            : saturating counters, CNT_W bits (CNT_W <= 64)
//   Trace*                            : show-ahead trace read port with valid/ready
//   TraceLevel, TraceDropCount        : occupancy and entries lost to a full FIFO
module pipeline_event_monitor
  import pipe_mon_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TRACE_DEPTH = 16,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Enable,
  input  logic                         ClearCounters,
  input  logic                         Stall,
  input  logic                         BranchTaken,
  input  logic                         Jump,
  input  logic                         WB_RegWrite,
  input  logic [REG_W-1:0]             WB_WriteRegister,
  input  logic [DATA_W-1:0]            WB_WriteData,
  input  logic [ADDR_W-1:0]            WB_PC,
  input  logic                         MEM_MemWrite,
  input  logic [ADDR_W-1:0]            MEM_PC,
  output logic [CNT_W-1:0]             CycleCount,
  output logic [CNT_W-1:0]             StallCount,
  output logic [CNT_W-1:0]             BranchCount,
  output logic [CNT_W-1:0]             JumpCount,
  output logic [CNT_W-1:0]             CommitCount,
  output logic [CNT_W-1:0]             StoreCount,
  output logic                         TraceValid,
  input  logic                         TraceReady,
  output logic                         TraceKind,
  output logic [REG_W-1:0]             TraceReg,
  output logic [DATA_W-1:0]            TraceData,
  output logic [ADDR_W-1:0]            TracePC,
  output logic [$clog2(TRACE_DEPTH):0] TraceLevel,
  output logic [CNT_W-1:0]             TraceDropCount
);

  localparam int EW   = trace_entry_w(REG_W, DATA_W, ADDR_W);
  localparam int NCNT = 7;
  // Counter slots
  localparam int C_CYC = 0, C_STL = 1, C_BR = 2, C_JMP = 3, C_CMT = 4, C_ST = 5, C_DROP = 6;

  logic [EW-1:0]   push_ent, head;
  logic            push_req, fifo_full, pop, drop;
  logic [NCNT-1:0] ev;
  logic [NCNT-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Commit wins the single trace slot; a simultaneous store is still counted.
  assign push_req = Enable & (WB_RegWrite | MEM_MemWrite);
  assign push_ent = WB_RegWrite
                  ? {TRACE_KIND_COMMIT, WB_WriteRegister, WB_WriteData, WB_PC}
                  : {TRACE_KIND_STORE, {REG_W{1'b0}}, {DATA_W{1'b0}}, MEM_PC};
  assign pop      = TraceValid & TraceReady;
  assign drop     = push_req & fifo_full & ~pop;

  trace_fifo #(.W(EW), .DEPTH(TRACE_DEPTH)) u_fifo (
    .clk    (Clk),
    .rst    (Reset),
    .push_i (push_req),
    .pop_i  (TraceReady),
    .din_i  (push_ent),
    .dout_o (head),
    .valid_o(TraceValid),
    .full_o (fifo_full),
    .level_o(TraceLevel)
  );

  assign {TraceKind, TraceReg, TraceData, TracePC} = head;

  always_comb begin
    ev         = '0;
    ev[C_CYC]  = Enable;
    ev[C_STL]  = Enable & Stall;
    ev[C_BR]   = Enable & BranchTaken;
    ev[C_JMP]  = Enable & Jump;
    ev[C_CMT]  = Enable & WB_RegWrite;
    ev[C_ST]   = Enable & MEM_MemWrite;
    ev[C_DROP] = drop;
  end

  always_comb begin
    logic [63:0] inc;
    cnt_d = cnt_q;
    inc   = '0;
    for (int i = 0; i < NCNT; i++) begin
      inc = sat_inc(64'(cnt_q[i]), CNT_W);
      if (ClearCounters) cnt_d[i] = '0;
      else if (ev[i])    cnt_d[i] = inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign CycleCount     = cnt_q[C_CYC];
  assign StallCount     = cnt_q[C_STL];
  assign BranchCount    = cnt_q[C_BR];
  assign JumpCount      = cnt_q[C_JMP];
  assign CommitCount    = cnt_q[C_CMT];
  assign StoreCount     = cnt_q[C_ST];
  assign TraceDropCount = cnt_q[C_DROP];

endmodule

// File: tb/tb_pipeline_event_monitor.sv
module tb_pipeline_event_monitor;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset, Enable, ClearCounters, Stall, BranchTaken, Jump;
  logic        WB_RegWrite, MEM_MemWrite, TraceReady;
  logic [4:0]  WB_WriteRegister;
  logic [31:0] WB_WriteData, WB_PC, MEM_PC;

  logic [31:0] CycleCount, StallCount, BranchCount, JumpCount, CommitCount, StoreCount, TraceDropCount;
  logic        TraceValid, TraceKind;
  logic [4:0]  TraceReg;
  logic [31:0] TraceData, TracePC;
  logic [4:0]  TraceLevel;

  logic [3:0]  c4_Cycle, c4_Stall, c4_Branch, c4_Jump, c4_Commit, c4_Store, c4_Drop;
  logic        c4_Valid, c4_Kind;
  logic [4:0]  c4_Reg;
  logic [31:0] c4_Data, c4_PC;
  logic [4:0]  c4_Level;

  pipeline_event_monitor dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .ClearCounters(ClearCounters),
    .Stall(Stall), .BranchTaken(BranchTaken), .Jump(Jump),
    .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister),
    .WB_WriteData(WB_WriteData), .WB_PC(WB_PC),
    .MEM_MemWrite(MEM_MemWrite), .MEM_PC(MEM_PC),
    .CycleCount(CycleCount), .StallCount(StallCount), .BranchCount(BranchCount),
    .JumpCount(JumpCount), .CommitCount(CommitCount), .StoreCount(StoreCount),
    .TraceValid(TraceValid), .TraceReady(TraceReady), .TraceKind(TraceKind),
    .TraceReg(TraceReg), .TraceData(TraceData), .TracePC(TracePC),
    .TraceLevel(TraceLevel), .TraceDropCount(TraceDropCount)
  );

  pipeline_event_monitor #(.CNT_W(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .ClearCounters(ClearCounters),
    .Stall(Stall), .BranchTaken(BranchTaken), .Jump(Jump),
    .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister),
    .WB_WriteData(WB_WriteData), .WB_PC(WB_PC),
    .MEM_MemWrite(MEM_MemWrite), .MEM_PC(MEM_PC),
    .CycleCount(c4_Cycle), .StallCount(c4_Stall), .BranchCount(c4_Branch),
    .JumpCount(c4_Jump), .CommitCount(c4_Commit), .StoreCount(c4_Store),
    .TraceValid(c4_Valid), .TraceReady(TraceReady), .TraceKind(c4_Kind),
    .TraceReg(c4_Reg), .TraceData(c4_Data), .TracePC(c4_PC),
    .TraceLevel(c4_Level), .TraceDropCount(c4_Drop)
  );

  typedef struct packed {
    logic        kind;
    logic [4:0]  r;
    logic [31:0] d;
    logic [31:0] pc;
  } ent_t;

  ent_t head;
  assign head = {TraceKind, TraceReg, TraceData, TracePC};

  ent_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_events;
    Stall = 0; BranchTaken = 0; Jump = 0;
    WB_RegWrite = 0; WB_WriteRegister = '0; WB_WriteData = '0; WB_PC = '0;
    MEM_MemWrite = 0; MEM_PC = '0;
  endtask

  task automatic do_reset;
    idle_events();
    Enable = 0; ClearCounters = 0; TraceReady = 0;
    Reset = 1;
    step(); step();
    Reset = 0;
    sb.delete();
  endtask

  task automatic drive_commit(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
    WB_RegWrite = 1; WB_WriteRegister = r; WB_WriteData = d; WB_PC = pc;
  endtask

  // Pops every scoreboard entry and compares the head before each pop.
  task automatic drain(input string tag);
    TraceReady = 1;
    for (int n = 0; n < 40 && sb.size() > 0; n++) begin
      checks++;
      if (TraceValid !== 1'b1 || head !== sb[0]) begin
        errors++;
        $display("FAIL %s_entry%0d valid=%b got=%h want=%h", tag, n, TraceValid, head, sb[0]);
      end
      step();
      void'(sb.pop_front());
    end
    TraceReady = 0;
    checks++;
    if (sb.size() != 0 || TraceValid !== 1'b0 || TraceLevel !== 5'd0) begin
      errors++;
      $display("FAIL %s_empty left=%0d valid=%b level=%0d want 0/0/0", tag, sb.size(), TraceValid, TraceLevel);
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (CycleCount !== 0 || StallCount !== 0 || CommitCount !== 0 || StoreCount !== 0 ||
        TraceDropCount !== 0 || TraceValid !== 0 || TraceLevel !== 0 || head !== '0) begin
      errors++;
      $display("FAIL reset_state cyc=%0d stl=%0d cmt=%0d st=%0d drop=%0d valid=%b level=%0d head=%h want all 0",
               CycleCount, StallCount, CommitCount, StoreCount, TraceDropCount, TraceValid, TraceLevel, head);
    end
  endtask

  task automatic test_idle_cycles;
    do_reset();
    Enable = 1;
    repeat (10) step();
    Enable = 0;
    checks++;
    if (CycleCount !== 32'd10) begin
      errors++; $display("FAIL idle_cycles got=%0d want=10", CycleCount);
    end
    checks++;
    if (StallCount !== 0 || BranchCount !== 0 || JumpCount !== 0 || CommitCount !== 0 ||
        StoreCount !== 0 || TraceValid !== 0) begin
      errors++;
      $display("FAIL idle_others stl=%0d br=%0d jmp=%0d cmt=%0d st=%0d valid=%b want 0",
               StallCount, BranchCount, JumpCount, CommitCount, StoreCount, TraceValid);
    end
  endtask

  task automatic test_commit;
    do_reset();
    Enable = 1;
    drive_commit(5'd8, -32'sd3, 32'h20);
    sb.push_back('{kind: 1'b0, r: 5'd8, d: 32'hFFFF_FFFD, pc: 32'h20});
    step();
    idle_events(); Enable = 0;
    checks++;
    if (TraceValid !== 1 || TraceKind !== 0 || TraceReg !== 5'd8 ||
        TraceData !== 32'hFFFF_FFFD || TracePC !== 32'h20) begin
      errors++;
      $display("FAIL commit_head valid=%b kind=%b reg=%0d data=%h pc=%h want 1/0/8/fffffffd/20",
               TraceValid, TraceKind, TraceReg, TraceData, TracePC);
    end
    checks++;
    if (CommitCount !== 1 || StoreCount !== 0) begin
      errors++; $display("FAIL commit_count cmt=%0d st=%0d want 1/0", CommitCount, StoreCount);
    end
    drain("commit");
  endtask

  task automatic test_commit_store;
    do_reset();
    Enable = 1;
    drive_commit(5'd9, 32'h1234_5678, 32'h40);
    MEM_MemWrite = 1; MEM_PC = 32'h44;
    sb.push_back('{kind: 1'b0, r: 5'd9, d: 32'h1234_5678, pc: 32'h40});
    step();
    idle_events();
    MEM_MemWrite = 1; MEM_PC = 32'h48;
    sb.push_back('{kind: 1'b1, r: 5'd0, d: 32'd0, pc: 32'h48});
    step();
    idle_events(); Enable = 0;
    checks++;
    if (StoreCount !== 2 || CommitCount !== 1 || TraceLevel !== 5'd2 || TraceDropCount !== 0) begin
      errors++;
      $display("FAIL both_counts st=%0d cmt=%0d level=%0d drop=%0d want 2/1/2/0",
               StoreCount, CommitCount, TraceLevel, TraceDropCount);
    end
    drain("both");
  endtask

  task automatic test_events;
    int es, eb, ej;
    es = 0; eb = 0; ej = 0;
    do_reset();
    Enable = 1;
    for (int i = 0; i < 8; i++) begin
      Stall = i[0]; BranchTaken = i[1]; Jump = (i % 3 == 0);
      es += i % 2; eb += (i / 2) % 2; ej += (i % 3 == 0) ? 1 : 0;
      step();
    end
    // Everything high with Enable low must be ignored.
    Enable = 0; Stall = 1; BranchTaken = 1; Jump = 1;
    drive_commit(5'd1, 32'd1, 32'd4); MEM_MemWrite = 1;
    step();
    idle_events();
    checks++;
    if (StallCount !== es || BranchCount !== eb || JumpCount !== ej || CycleCount !== 8) begin
      errors++;
      $display("FAIL event_counts stl=%0d br=%0d jmp=%0d cyc=%0d want %0d/%0d/%0d/8",
               StallCount, BranchCount, JumpCount, CycleCount, es, eb, ej);
    end
    checks++;
    if (CommitCount !== 0 || StoreCount !== 0 || TraceValid !== 0) begin
      errors++;
      $display("FAIL disabled_push cmt=%0d st=%0d valid=%b want 0/0/0", CommitCount, StoreCount, TraceValid);
    end
  endtask

  task automatic test_overflow;
    int exp_drop;
    ent_t e;
    exp_drop = 0;
    do_reset();
    Enable = 1;
    for (int i = 0; i < 18; i++) begin
      e = '{kind: 1'b0, r: 5'(i + 1), d: 32'hA000_0000 + 32'(i), pc: 32'(i * 4)};
      drive_commit(e.r, e.d, e.pc);
      if (sb.size() < 16) sb.push_back(e);
      else exp_drop++;
      step();
    end
    idle_events();
    checks++;
    if (TraceLevel !== 5'd16 || TraceDropCount !== 32'(exp_drop)) begin
      errors++;
      $display("FAIL overflow level=%0d drop=%0d want 16/%0d", TraceLevel, TraceDropCount, exp_drop);
    end
    // Push and pop on the same edge while full.
    checks++;
    if (head !== sb[0]) begin
      errors++; $display("FAIL full_head got=%h want=%h", head, sb[0]);
    end
    TraceReady = 1;
    e = '{kind: 1'b0, r: 5'd31, d: 32'hDEAD_BEEF, pc: 32'h100};
    drive_commit(e.r, e.d, e.pc);
    step();
    void'(sb.pop_front());
    sb.push_back(e);
    TraceReady = 0;
    idle_events();
    checks++;
    if (TraceLevel !== 5'd16 || TraceDropCount !== 32'(exp_drop)) begin
      errors++;
      $display("FAIL full_pushpop level=%0d drop=%0d want 16/%0d", TraceLevel, TraceDropCount, exp_drop);
    end
    drain("overflow");
  endtask

  task automatic test_saturate;
    do_reset();
    Enable = 1;
    for (int i = 0; i < 3; i++) begin
      drive_commit(5'(i + 3), 32'(i * 7), 32'h200 + 32'(i * 4));
      sb.push_back('{kind: 1'b0, r: 5'(i + 3), d: 32'(i * 7), pc: 32'h200 + 32'(i * 4)});
      step();
    end
    idle_events();
    Stall = 1;
    repeat (20) step();
    Stall = 0;
    checks++;
    if (c4_Stall !== 4'd15 || c4_Cycle !== 4'd15) begin
      errors++; $display("FAIL sat4 stall=%0d cyc=%0d want 15/15", c4_Stall, c4_Cycle);
    end
    checks++;
    if (StallCount !== 32'd20) begin
      errors++; $display("FAIL stall32 got=%0d want=20", StallCount);
    end
    ClearCounters = 1;
    step();
    ClearCounters = 0;
    checks++;
    if (StallCount !== 0 || CycleCount !== 0 || CommitCount !== 0 || c4_Stall !== 0 || c4_Cycle !== 0) begin
      errors++;
      $display("FAIL clear stl=%0d cyc=%0d cmt=%0d s4=%0d c4=%0d want 0",
               StallCount, CycleCount, CommitCount, c4_Stall, c4_Cycle);
    end
    checks++;
    if (TraceLevel !== 5'd3 || c4_Level !== 5'd3) begin
      errors++; $display("FAIL clear_keeps_fifo level=%0d l4=%0d want 3", TraceLevel, c4_Level);
    end
    Enable = 0;
    drain("sat");
  endtask

  task automatic test_back_to_back;
    logic popping;
    do_reset();
    Enable = 1;
    TraceReady = 1;
    for (int i = 0; i < 10; i++) begin
      idle_events();
      if (i < 8) begin
        drive_commit(5'(i), 32'h5500 + 32'(i), 32'h300 + 32'(i * 4));
        sb.push_back('{kind: 1'b0, r: 5'(i), d: 32'h5500 + 32'(i), pc: 32'h300 + 32'(i * 4)});
      end
      popping = TraceValid;
      if (popping) begin
        checks++;
        if (head !== sb[0]) begin
          errors++; $display("FAIL b2b_%0d got=%h want=%h", i, head, sb[0]);
        end
      end
      step();
      if (popping) void'(sb.pop_front());
    end
    idle_events();
    drain("b2b");
    checks++;
    if (CommitCount !== 8 || TraceDropCount !== 0) begin
      errors++; $display("FAIL b2b_counts cmt=%0d drop=%0d want 8/0", CommitCount, TraceDropCount);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    Enable = 1;
    for (int i = 0; i < 5; i++) begin
      drive_commit(5'(i + 10), 32'(i), 32'h400 + 32'(i * 4));
      Stall = 1;
      step();
    end
    idle_events();
    TraceReady = 1;
    drive_commit(5'd2, 32'd2, 32'h500);
    Reset = 1;
    step();
    Reset = 0; TraceReady = 0; Enable = 0;
    idle_events();
    sb.delete();
    checks++;
    if (TraceLevel !== 0 || TraceValid !== 0 || head !== '0) begin
      errors++; $display("FAIL midreset_fifo level=%0d valid=%b head=%h want 0", TraceLevel, TraceValid, head);
    end
    checks++;
    if (CycleCount !== 0 || StallCount !== 0 || CommitCount !== 0 || TraceDropCount !== 0) begin
      errors++;
      $display("FAIL midreset_cnt cyc=%0d stl=%0d cmt=%0d drop=%0d want 0",
               CycleCount, StallCount, CommitCount, TraceDropCount);
    end
  endtask

  initial begin
    test_reset();
    test_idle_cycles();
    test_commit();
    test_commit_store();
    test_events();
    test_overflow();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
